// File: rtl/round_robin_dispatch_if.sv
// Handshake bundle between the upstream stream, the worker lanes and round_robin_dispatch.
// The dispatcher takes the slave side; the stream/worker side takes the master side.
interface round_robin_dispatch_if #(
    parameter int unsigned width     = 8,
    parameter int unsigned n_outputs = 10
);
    localparam int unsigned CntW = $clog2(n_outputs + 1);

    logic                                in_vld;
    logic                                in_rdy;
    logic [width-1:0]                    in_data;
    logic [n_outputs-1:0]                out_vlds;
    logic [n_outputs-1:0][width-1:0]     out_data;
    logic [n_outputs-1:0]                done_vlds;
    logic [CntW-1:0]                     n_busy;
    logic                                idle;
    logic                                err;

    modport master (
        output in_vld, in_data, done_vlds,
        input  in_rdy, out_vlds, out_data, n_busy, idle, err
    );

    modport slave (
        input  in_vld, in_data, done_vlds,
        output in_rdy, out_vlds, out_data, n_busy, idle, err
    );
endinterface

// File: rtl/round_robin_dispatch.sv
// Deals an in-order token stream round-robin onto worker lanes, one token in flight per lane.
// Strict order: a busy lane at the pointer stalls the stream even if other lanes are free.
module round_robin_dispatch #(
    parameter int unsigned width     = 8,
    parameter int unsigned n_outputs = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    round_robin_dispatch_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(n_outputs);
    localparam int unsigned CntW = $clog2(n_outputs + 1);

    logic [PtrW-1:0]                 r_ptr;
    logic [PtrW-1:0]                 w_ptr_d;
    logic [n_outputs-1:0]            r_busy;
    logic [n_outputs-1:0]            w_busy_d;
    logic [n_outputs-1:0]            r_out_vlds;
    logic [n_outputs-1:0]            w_launch;
    logic [n_outputs-1:0]            w_done_ok;
    logic [n_outputs-1:0][width-1:0] r_out_data;
    logic [CntW-1:0]                 r_n_busy;
    logic [CntW-1:0]                 w_n_busy_d;
    logic                            r_err;
    logic                            w_rdy;
    logic                            w_accept;
    logic                            w_done_bad;

    always_comb begin
        w_rdy      = rst_n & ~r_busy[r_ptr];
        w_accept   = bus.in_vld & w_rdy;
        w_launch   = '0;
        if (w_accept) begin
            w_launch[r_ptr] = 1'b1;
        end
        // A done on the lane being launched this edge sees busy=0 and is an error.
        w_done_ok  = bus.done_vlds & r_busy;
        w_done_bad = |(bus.done_vlds & ~r_busy);
        w_busy_d   = (r_busy & ~w_done_ok) | w_launch;

        w_ptr_d = r_ptr;
        if (w_accept) begin
            w_ptr_d = (r_ptr == PtrW'(n_outputs - 1)) ? '0 : r_ptr + PtrW'(1);
        end

        w_n_busy_d = '0;
        for (int i = 0; i < int'(n_outputs); i++) begin
            w_n_busy_d = w_n_busy_d + CntW'(w_busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_busy     <= '0;
            r_out_vlds <= '0;
            r_out_data <= '0;
            r_n_busy   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_d;
            r_busy     <= w_busy_d;
            r_out_vlds <= w_launch;
            r_n_busy   <= w_n_busy_d;
            if (w_accept) begin
                r_out_data[r_ptr] <= bus.in_data;
            end
            if (w_done_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_rdy   = w_rdy;
    assign bus.out_vlds = r_out_vlds;
    assign bus.out_data = r_out_data;
    assign bus.n_busy   = r_n_busy;
    assign bus.idle     = (r_n_busy == '0);
    assign bus.err      = r_err;
endmodule

// File: tb/tb_round_robin_dispatch.sv
// Directed and random-stream bench for round_robin_dispatch with a reorder model on the
// worker side that stands in for put_in_order.
module tb_round_robin_dispatch;
    localparam int W = 8;
    localparam int N = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    round_robin_dispatch_if #(.width(W), .n_outputs(N)) bus ();

    round_robin_dispatch #(.width(W), .n_outputs(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_vld    = 1'b0;
        bus.in_data   = '0;
        bus.done_vlds = '0;
        #1;
        step();
        checks++; if (bus.in_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_in_rdy got %b exp 0", bus.in_rdy); end
        checks++; if (bus.idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle got %b exp 1", bus.idle); end
        checks++; if (bus.out_vlds !== 10'h000) begin
            errors++; $display("FAIL reset_out_vlds got %h exp 000", bus.out_vlds); end
        checks++; if (bus.n_busy !== 4'd0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_nbusy_err got %0d/%b exp 0/0", bus.n_busy, bus.err); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.in_rdy !== 1'b1) begin
            errors++; $display("FAIL release_in_rdy got %b exp 1", bus.in_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_v;
        for (int i = 0; i < N; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'(i);
            checks++; if (bus.in_rdy !== 1'b1) begin
                errors++; $display("FAIL b2b_rdy[%0d] got %b exp 1", i, bus.in_rdy); end
            step();
            exp_v = 10'h001 << i;
            checks++; if (bus.out_vlds !== exp_v || bus.out_data[i] !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_launch[%0d] got %h/%h exp %h/%h", i, bus.out_vlds,
                         bus.out_data[i], exp_v, 8'(i));
            end
        end
        bus.in_vld = 1'b0;
        checks++; if (bus.n_busy !== 4'd10 || bus.in_rdy !== 1'b0 || bus.idle !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full got nbusy=%0d rdy=%b idle=%b exp 10/0/0", bus.n_busy,
                     bus.in_rdy, bus.idle);
        end
        step();
        checks++; if (bus.out_vlds !== 10'h000) begin
            errors++; $display("FAIL b2b_no_launch got %h exp 000", bus.out_vlds); end
    endtask

    task automatic test_stall();
        bus.done_vlds = 10'h008;
        step();
        bus.done_vlds = '0;
        checks++; if (bus.in_rdy !== 1'b0 || bus.n_busy !== 4'd9) begin
            errors++;
            $display("FAIL stall_lane3 got rdy=%b nbusy=%0d exp 0/9", bus.in_rdy, bus.n_busy);
        end
        bus.done_vlds = 10'h001;
        #1;
        checks++; if (bus.in_rdy !== 1'b0) begin
            errors++; $display("FAIL stall_no_bypass got %b exp 0", bus.in_rdy); end
        step();
        bus.done_vlds = '0;
        checks++; if (bus.in_rdy !== 1'b1) begin
            errors++; $display("FAIL stall_lane0_free got %b exp 1", bus.in_rdy); end
        bus.in_vld  = 1'b1;
        bus.in_data = 8'h0A;
        step();
        bus.in_vld = 1'b0;
        checks++; if (bus.out_vlds !== 10'h001 || bus.out_data[0] !== 8'h0A ||
                      bus.n_busy !== 4'd9) begin
            errors++;
            $display("FAIL stall_tok0a got v=%h d=%h nbusy=%0d exp 001/0a/9", bus.out_vlds,
                     bus.out_data[0], bus.n_busy);
        end
    endtask

    task automatic test_concurrent();
        logic [N-1:0] exp_v;
        bus.done_vlds = 10'h006;
        step();
        bus.done_vlds = '0;
        checks++; if (bus.n_busy !== 4'd7 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL multi_done got nbusy=%0d err=%b exp 7/0", bus.n_busy, bus.err);
        end
        for (int i = 1; i <= 3; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'(8'h0A + i);
            step();
            exp_v = 10'h001 << i;
            checks++; if (bus.out_vlds !== exp_v || bus.out_data[i] !== 8'(8'h0A + i)) begin
                errors++;
                $display("FAIL refill[%0d] got %h/%h exp %h/%h", i, bus.out_vlds,
                         bus.out_data[i], exp_v, 8'(8'h0A + i));
            end
        end
        bus.in_vld = 1'b0;
        checks++; if (bus.n_busy !== 4'd10 || bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL refill_full got nbusy=%0d rdy=%b exp 10/0", bus.n_busy, bus.in_rdy);
        end
        bus.done_vlds = 10'h010;
        step();
        bus.done_vlds = '0;
        checks++; if (bus.n_busy !== 4'd9 || bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL free_lane4 got nbusy=%0d rdy=%b exp 9/1", bus.n_busy, bus.in_rdy);
        end
        bus.in_vld    = 1'b1;
        bus.in_data   = 8'h0E;
        bus.done_vlds = 10'h004;
        step();
        bus.in_vld    = 1'b0;
        bus.done_vlds = '0;
        checks++; if (bus.out_vlds !== 10'h010 || bus.out_data[4] !== 8'h0E) begin
            errors++;
            $display("FAIL concur_launch got %h/%h exp 010/0e", bus.out_vlds, bus.out_data[4]);
        end
        checks++; if (bus.n_busy !== 4'd9 || bus.err !== 1'b0 || bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL concur_state got nbusy=%0d err=%b rdy=%b exp 9/0/0", bus.n_busy,
                     bus.err, bus.in_rdy);
        end
    endtask

    task automatic test_error();
        bus.done_vlds = 10'h080;
        step();
        checks++; if (bus.n_busy !== 4'd8 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_legal got nbusy=%0d err=%b exp 8/0", bus.n_busy, bus.err);
        end
        step();
        bus.done_vlds = '0;
        checks++; if (bus.err !== 1'b1 || bus.n_busy !== 4'd8) begin
            errors++;
            $display("FAIL err_set got err=%b nbusy=%0d exp 1/8", bus.err, bus.n_busy);
        end
        repeat (3) step();
        checks++; if (bus.err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b0 || bus.n_busy !== 4'd0 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL err_reset got err=%b nbusy=%0d idle=%b exp 0/0/1", bus.err,
                     bus.n_busy, bus.idle);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random_stream();
        logic         inflight [N];
        int           cnt      [N];
        logic [W-1:0] ldata    [N];
        logic         comp     [N];
        logic [W-1:0] cres     [N];
        logic [N-1:0] done;
        int           sent;
        int           emitted;
        int           rd;
        int           cyc;
        sent = 0; emitted = 0; rd = 0; cyc = 0;
        for (int l = 0; l < N; l++) begin
            inflight[l] = 1'b0; cnt[l] = 0; ldata[l] = '0; comp[l] = 1'b0; cres[l] = '0;
        end
        while (emitted < 1000 && cyc < 10000) begin
            if ($countones(bus.out_vlds) > 1) begin
                checks++; errors++;
                $display("FAIL rand_onehot got %h exp one-hot", bus.out_vlds);
            end
            for (int l = 0; l < N; l++) begin
                if (bus.out_vlds[l]) begin
                    if (inflight[l] || comp[l]) begin
                        checks++; errors++;
                        $display("FAIL rand_double_launch lane %0d got launch exp idle", l);
                    end
                    inflight[l] = 1'b1;
                    ldata[l]    = bus.out_data[l];
                    cnt[l]      = int'($urandom_range(0, N - 1));
                end
            end
            done = '0;
            for (int l = 0; l < N; l++) begin
                if (inflight[l]) begin
                    if (cnt[l] == 0) begin
                        done[l] = 1'b1; inflight[l] = 1'b0; comp[l] = 1'b1; cres[l] = ldata[l];
                    end else begin
                        cnt[l]--;
                    end
                end
            end
            bus.done_vlds = done;
            while (comp[rd]) begin
                checks++;
                if (cres[rd] !== 8'(emitted)) begin
                    errors++;
                    $display("FAIL rand_order[%0d] got %h exp %h", emitted, cres[rd],
                             8'(emitted));
                end
                comp[rd] = 1'b0;
                emitted++;
                rd = (rd == N - 1) ? 0 : rd + 1;
            end
            if (sent < 1000) begin
                bus.in_vld  = ($urandom_range(0, 3) != 0);
                bus.in_data = 8'(sent);
                if (bus.in_vld && bus.in_rdy) sent++;
            end else begin
                bus.in_vld = 1'b0;
            end
            step();
            cyc++;
        end
        bus.in_vld    = 1'b0;
        bus.done_vlds = '0;
        checks++; if (emitted !== 1000) begin
            errors++; $display("FAIL rand_timeout got %0d exp 1000 tokens", emitted); end
        checks++; if (bus.err !== 1'b0 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL rand_end got err=%b idle=%b exp 0/1", bus.err, bus.idle);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_concurrent();
        test_error();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
